// File: rtl/instr_encode_loader.sv
// Sequential instruction encoder and program loader: packs (ID, rs, rt, rd) into
// the machine word the decoder expects and writes it to instruction memory.
module instr_encode_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_id,
    input  logic [31:0]       in_rs,
    input  logic [31:0]       in_rt,
    input  logic [31:0]       in_rd,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [1:0] {IDLE, ENC, WR} state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [31:0]       id_q, rs_q, rt_q, rd_q;
    logic              last_q;
    logic [31:0]       word_q;

    logic [4:0]        id5, rs5, rt5, rd5;
    logic [15:0]       imm16;
    logic [5:0]        op_m4, op_m5, func_m1, func_m11;
    logic              r_ok, i_ok, j_ok, range_ok;
    logic [31:0]       enc_word;
    logic [1:0]        enc_err;

    function automatic logic fits_u5(input logic [31:0] v);
        return v[31:5] == '0;
    endfunction

    function automatic logic fits_s16(input logic [31:0] v);
        return (v[31:15] == '0) || (v[31:15] == '1);
    endfunction

    function automatic logic fits_u26(input logic [31:0] v);
        return v[31:26] == '0;
    endfunction

    assign id5      = id_q[4:0];
    assign rs5      = rs_q[4:0];
    assign rt5      = rt_q[4:0];
    assign rd5      = rd_q[4:0];
    assign imm16    = rt_q[15:0];
    assign op_m4    = {1'b0, id5} - 6'd4;
    assign op_m5    = {1'b0, id5} - 6'd5;
    assign func_m1  = {1'b0, id5} - 6'd1;
    assign func_m11 = {1'b0, id5} - 6'd11;

    // Register-only layouts (R and shift) all need three 5-bit fields.
    assign r_ok = fits_u5(rs_q) && fits_u5(rt_q) && fits_u5(rd_q);
    assign i_ok = fits_u5(rs_q) && fits_u5(rd_q) && fits_s16(rt_q);
    assign j_ok = fits_u26(rs_q);

    always_comb begin
        enc_word = '0;
        range_ok = 1'b1;
        enc_err  = 2'd0;
        case (id5)
            5'd1, 5'd2, 5'd3, 5'd4: begin
                enc_word = {6'd0, rs5, rt5, rd5, 5'd0, func_m1};
                range_ok = r_ok;
            end
            5'd7, 5'd8: begin
                enc_word = {op_m4, rs5, rt5, rd5, 11'd0};
                range_ok = r_ok;
            end
            5'd5, 5'd6, 5'd9, 5'd10: begin
                enc_word = {op_m4, rs5, rd5, imm16};
                range_ok = i_ok;
            end
            5'd11, 5'd12: begin
                enc_word = {6'd7, 5'd0, rs5, rd5, rt5, func_m11};
                range_ok = r_ok;
            end
            5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd25: begin
                enc_word = {op_m5, rs5, rd5, imm16};
                range_ok = i_ok;
            end
            5'd21, 5'd22, 5'd23: begin
                enc_word = {op_m5, rs_q[25:0]};
                range_ok = j_ok;
            end
            5'd24, 5'd26: begin
                enc_word = {op_m5, rs5, rt5, rd5, 11'd0};
                range_ok = r_ok;
            end
            default: begin
                enc_word = '0;
                range_ok = 1'b1;
            end
        endcase
        if (id_q > 32'd26) begin
            enc_err = 2'd1;
        end else if (!range_ok) begin
            enc_err = 2'd2;
        end else if (word_count == FULL_COUNT) begin
            enc_err = 2'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!start && in_valid) state_d = ENC;
            ENC:  state_d = (enc_err != 2'd0) ? IDLE : WR;
            WR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            word_count <= '0;
            err        <= 1'b0;
            err_code   <= 2'd0;
            done       <= 1'b0;
            word_q     <= '0;
            id_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= (state_q == WR) && last_q;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ptr_q      <= base_addr;
                        word_count <= '0;
                        err        <= 1'b0;
                        err_code   <= 2'd0;
                    end else if (in_valid) begin
                        id_q   <= in_id;
                        rs_q   <= in_rs;
                        rt_q   <= in_rt;
                        rd_q   <= in_rd;
                        last_q <= in_last;
                    end
                end
                ENC: begin
                    if (enc_err != 2'd0) begin
                        err      <= 1'b1;
                        err_code <= enc_err;
                    end else begin
                        word_q <= enc_word;
                    end
                end
                WR: begin
                    ptr_q      <= ptr_q + 1'b1;
                    word_count <= word_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Reset gates the strobe so an aborted WR cycle never reaches memory.
    assign mem_we    = (state_q == WR) && !reset;
    assign mem_addr  = ptr_q;
    assign mem_wdata = word_q;
    assign in_ready  = (state_q == IDLE) && !start;
    assign busy      = (state_q == ENC) || (state_q == WR);

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: a full-size instance and a DEPTH=4
// instance, with expected memory writes queued at drive time and popped on mem_we.
module tb_instr_encode_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic [7:0]  base_addr;
    logic        valid_a, valid_b;
    logic [31:0] in_id, in_rs, in_rt, in_rd;
    logic        in_last;

    logic        in_ready_a, mem_we_a, busy_a, done_a, err_a;
    logic [7:0]  mem_addr_a;
    logic [31:0] mem_wdata_a;
    logic [8:0]  word_count_a;
    logic [1:0]  err_code_a;

    logic        in_ready_b, mem_we_b, busy_b, done_b, err_b;
    logic [7:0]  mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [8:0]  word_count_b;
    logic [1:0]  err_code_b;

    int          total = 0;
    int          bad   = 0;
    logic [39:0] q_a[$];
    logic [39:0] q_b[$];
    logic [39:0] item_a, item_b;
    logic [7:0]  exp_ptr_a, exp_ptr_b;

    always #5 clk = ~clk;

    instr_encode_loader #(.ADDR_W(8), .DEPTH(256)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .base_addr(base_addr),
        .in_valid(valid_a), .in_ready(in_ready_a), .in_id(in_id), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_last(in_last), .mem_we(mem_we_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .word_count(word_count_a),
        .busy(busy_a), .done(done_a), .err(err_a), .err_code(err_code_a)
    );

    instr_encode_loader #(.ADDR_W(8), .DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .base_addr(base_addr),
        .in_valid(valid_b), .in_ready(in_ready_b), .in_id(in_id), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_last(in_last), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .word_count(word_count_b),
        .busy(busy_b), .done(done_b), .err(err_b), .err_code(err_code_b)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
        end
    endtask

    task automatic applyStart(input bit sel, input logic [7:0] base);
        base_addr = base;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        start_b = 1'b0;
        if (sel) exp_ptr_b = base; else exp_ptr_a = base;
    endtask

    // Returns one cycle after the transfer edge, i.e. during the ENC cycle.
    task automatic applyStimulus(input bit sel, input logic [31:0] id, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic [31:0] rd, input logic last,
                                 input bit expect_write, input logic [31:0] exp_data);
        int waited = 0;
        while (!(sel ? in_ready_b : in_ready_a) && waited < 50) begin
            tick(1);
            waited++;
        end
        checkOutput("handshake_wait", 32'(waited < 50), 32'd1);
        if (waited < 50) begin
            in_id   = id;
            in_rs   = rs;
            in_rt   = rt;
            in_rd   = rd;
            in_last = last;
            if (sel) valid_b = 1'b1; else valid_a = 1'b1;
            if (expect_write) begin
                if (sel) begin
                    q_b.push_back({exp_ptr_b, exp_data});
                    exp_ptr_b = exp_ptr_b + 8'd1;
                end else begin
                    q_a.push_back({exp_ptr_a, exp_data});
                    exp_ptr_a = exp_ptr_a + 8'd1;
                end
            end
            tick(1);
            valid_a = 1'b0;
            valid_b = 1'b0;
            in_last = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (mem_we_a) begin
            checkOutput("write_expected_a", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) begin
                item_a = q_a.pop_front();
                checkOutput("wr_addr_a", {24'd0, mem_addr_a}, {24'd0, item_a[39:32]});
                checkOutput("wr_data_a", mem_wdata_a, item_a[31:0]);
            end
        end
        if (mem_we_b) begin
            checkOutput("write_expected_b", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) begin
                item_b = q_b.pop_front();
                checkOutput("wr_addr_b", {24'd0, mem_addr_b}, {24'd0, item_b[39:32]});
                checkOutput("wr_data_b", mem_wdata_b, item_b[31:0]);
            end
        end
    end

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; base_addr = '0;
        valid_a = 1'b0; valid_b = 1'b0; in_last = 1'b0;
        in_id = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        exp_ptr_a = '0; exp_ptr_b = '0;
        tick(3);
        reset = 1'b0;
        tick(1);
        checkOutput("rst_in_ready", 32'(in_ready_a), 32'd1);
        checkOutput("rst_mem_we", 32'(mem_we_a), 32'd0);
        checkOutput("rst_mem_addr", {24'd0, mem_addr_a}, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata_a, 32'd0);
        checkOutput("rst_word_count", 32'(word_count_a), 32'd0);
        checkOutput("rst_busy", 32'(busy_a), 32'd0);
        checkOutput("rst_done", 32'(done_a), 32'd0);
        checkOutput("rst_err", {29'd0, err_a, err_code_a}, 32'd0);

        $display("[TB] add with latency check");
        applyStart(1'b0, 8'h10);
        applyStimulus(1'b0, 32'd1, 32'd1, 32'd2, 32'd3, 1'b0, 1'b1, 32'h0022_1800);
        checkOutput("enc_mem_we", 32'(mem_we_a), 32'd0);
        checkOutput("enc_busy", 32'(busy_a), 32'd1);
        checkOutput("enc_in_ready", 32'(in_ready_a), 32'd0);
        tick(1);
        checkOutput("wr_mem_we", 32'(mem_we_a), 32'd1);
        checkOutput("wr_mem_addr", {24'd0, mem_addr_a}, 32'h10);
        checkOutput("wr_mem_wdata", mem_wdata_a, 32'h0022_1800);
        tick(1);
        checkOutput("post_in_ready", 32'(in_ready_a), 32'd1);
        checkOutput("post_word_count", 32'(word_count_a), 32'd1);
        checkOutput("post_busy", 32'(busy_a), 32'd0);

        $display("[TB] addi then srl with in_last");
        applyStimulus(1'b0, 32'd5, 32'd1, 32'hFFFF_FFFF, 32'd4, 1'b0, 1'b1, 32'h0424_FFFF);
        applyStimulus(1'b0, 32'd12, 32'd5, 32'd3, 32'd6, 1'b1, 1'b1, 32'h1C05_30C1);
        checkOutput("done_early", 32'(done_a), 32'd0);
        tick(2);
        checkOutput("done_pulse", 32'(done_a), 32'd1);
        checkOutput("count_after_srl", 32'(word_count_a), 32'd3);
        tick(1);
        checkOutput("done_clear", 32'(done_a), 32'd0);

        $display("[TB] jump, bad id, zero word");
        applyStimulus(1'b0, 32'd21, 32'd100, 32'd0, 32'd0, 1'b0, 1'b1, 32'h4000_0064);
        applyStimulus(1'b0, 32'd27, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick(1);
        checkOutput("badid_err", 32'(err_a), 32'd1);
        checkOutput("badid_code", 32'(err_code_a), 32'd1);
        checkOutput("badid_count", 32'(word_count_a), 32'd4);
        checkOutput("badid_ready", 32'(in_ready_a), 32'd1);
        applyStimulus(1'b0, 32'd0, 32'd7, 32'd7, 32'd7, 1'b0, 1'b1, 32'h0000_0000);
        tick(2);
        checkOutput("sticky_err", 32'(err_a), 32'd1);
        checkOutput("zero_count", 32'(word_count_a), 32'd5);

        $display("[TB] range errors and start clearing");
        applyStimulus(1'b0, 32'd5, 32'd1, 32'd40000, 32'd4, 1'b0, 1'b0, 32'd0);
        tick(1);
        checkOutput("imm_range_code", 32'(err_code_a), 32'd2);
        applyStart(1'b0, 8'h20);
        checkOutput("start_clr_err", {29'd0, err_a, err_code_a}, 32'd0);
        checkOutput("start_clr_count", 32'(word_count_a), 32'd0);
        applyStimulus(1'b0, 32'd1, 32'd1, 32'd2, 32'd32, 1'b0, 1'b0, 32'd0);
        tick(1);
        checkOutput("rd_range_err", {29'd0, err_a, err_code_a}, 32'h6);
        applyStart(1'b0, 8'h20);
        checkOutput("start_clr_err2", {29'd0, err_a, err_code_a}, 32'd0);

        $display("[TB] small memory with address wrap");
        applyStart(1'b1, 8'hFE);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 32'd1, 32'd0, 32'd0, 32'(k), 1'b0, 1'b1, 32'(k) << 11);
        end
        applyStimulus(1'b1, 32'd1, 32'd0, 32'd0, 32'd5, 1'b0, 1'b0, 32'd0);
        tick(1);
        checkOutput("full_err", {29'd0, err_b, err_code_b}, 32'h7);
        checkOutput("full_count", 32'(word_count_b), 32'd4);

        $display("[TB] reset during ENC");
        applyStimulus(1'b0, 32'd7, 32'd2, 32'd3, 32'd4, 1'b0, 1'b1, 32'h0C43_2000);
        tick(2);
        checkOutput("pre_reset_count", 32'(word_count_a), 32'd1);
        applyStimulus(1'b0, 32'd1, 32'd1, 32'd1, 32'd1, 1'b0, 1'b0, 32'd0);
        reset = 1'b1;
        tick(1);
        checkOutput("abort_mem_we", 32'(mem_we_a), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready_a), 32'd1);
        checkOutput("abort_count", 32'(word_count_a), 32'd0);
        checkOutput("abort_busy", 32'(busy_a), 32'd0);
        reset = 1'b0;
        tick(3);
        checkOutput("abort_no_write", 32'(mem_we_a), 32'd0);

        checkOutput("queue_a_empty", 32'(q_a.size()), 32'd0);
        checkOutput("queue_b_empty", 32'(q_b.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
